cp0_regs: RTL and testbench

Coprocessor-0 register file and exception sequencer for the unpipelined MIPS core. It consumes the mtc0/mfc0/eret/unknown-function decode flags produced by ALU-control decode, plus ALU overflow and external interrupt lines. It holds Count/Compare/Status/Cause/EPC, decides exception entry and return each committed instruction, and supplies the next-PC redirect to the fetch stage.

---
 rtl/cp0_defs.sv | 49 ++++
 rtl/cp0_timer.sv | 62 ++++++
 rtl/cp0_regs.sv | 123 ++++++++++++
 tb/tb_cp0_regs.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register map, exception codes, Status/Cause layout.
package cp0_defs;

    // CP0 register addresses (rd field of mtc0/mfc0)
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // ExcCode values written into Cause
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    // Bit positions inside Status and Cause
    localparam int ST_IE      = 0;
    localparam int ST_EXL     = 1;
    localparam int ST_IM_LSB  = 8;
    localparam int CA_IP_LSB  = 8;
    localparam int CA_EXC_LSB = 2;

    typedef struct packed {
        logic [7:0] im;
        logic       exl;
        logic       ie;
    } status_t;

    // Out of reset the core sits in exception level with interrupts off.
    localparam status_t STATUS_RST = '{im: 8'h00, exl: 1'b1, ie: 1'b0};

    function automatic logic [31:0] status_word(input status_t s);
        logic [31:0] w;
        w                   = '0;
        w[ST_IE]            = s.ie;
        w[ST_EXL]           = s.exl;
        w[ST_IM_LSB +: 8]   = s.im;
        return w;
    endfunction

    function automatic logic [31:0] cause_word(input logic [7:0] ip, input logic [4:0] code);
        logic [31:0] w;
        w                   = '0;
        w[CA_IP_LSB +: 8]   = ip;
        w[CA_EXC_LSB +: 5]  = code;
        return w;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled free-running Count, Compare match flag.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_timer_flag
);

    logic        presc_q, presc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        flag_q, flag_d;
    logic        tick;

    // Next-state for prescaler, Count, Compare and the match flag
    always_comb begin
        tick      = (COUNT_DIV == 1) ? 1'b1 : presc_q;
        presc_d   = (COUNT_DIV == 1) ? 1'b0 : ~presc_q;
        count_d   = tick ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        flag_d    = flag_q;
        // A software write to Count beats the increment and restarts the divider.
        if (i_count_we) begin
            count_d = i_wdata;
            presc_d = 1'b0;
        end
        if (i_compare_we) begin
            compare_d = i_wdata;
        end
        // Writing Compare is the only way to acknowledge the timer interrupt.
        if (i_compare_we)
            flag_d = 1'b0;
        else if (count_q == compare_q)
            flag_d = 1'b1;
    end

    // Timer state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q   <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            flag_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            flag_q    <= flag_d;
        end
    end

    assign o_count      = count_q;
    assign o_compare    = compare_q;
    assign o_timer_flag = flag_q;

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file and exception sequencer for the unpipelined MIPS core.
module cp0_regs
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inst_valid,
    input  logic [31:0] i_pc,
    input  logic        i_mtc0,
    input  logic        i_mfc0,
    input  logic        i_eret,
    input  logic        i_unknown_func,
    input  logic        i_overflow,
    input  logic [4:0]  i_cp0_addr,
    input  logic [31:0] i_wdata,
    input  logic [5:0]  i_hw_irq,
    output logic [31:0] o_rdata,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_exc_taken
);

    status_t     status_q, status_d;
    logic [5:0]  ip_hw_q;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic [31:0] count, compare;
    logic        timer_flag;
    logic [7:0]  cause_ip;
    logic        irq_pend, exc, do_eret, do_mtc0;
    logic [4:0]  exc_code;

    // The read select has no side effects; o_rdata always follows the address.
    logic unused_mfc0;
    assign unused_mfc0 = i_mfc0;

    // Exception arbitration: RI > OV > interrupt, then eret, then mtc0
    always_comb begin
        cause_ip = {ip_hw_q[5] | timer_flag, ip_hw_q[4:0], ip_sw_q};
        irq_pend = status_q.ie & ~status_q.exl & (|(cause_ip & status_q.im));
        exc      = i_rst_n & i_inst_valid & (i_unknown_func | i_overflow | irq_pend);
        exc_code = i_unknown_func ? EXC_RI : (i_overflow ? EXC_OV : EXC_INT);
        do_eret  = i_rst_n & i_inst_valid & i_eret & ~exc;
        do_mtc0  = i_rst_n & i_inst_valid & i_mtc0 & ~exc;
    end

    // Next-state for Status, Cause (software bits and ExcCode) and EPC
    always_comb begin
        status_d   = status_q;
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (exc) begin
            exc_code_d   = exc_code;
            status_d.exl = 1'b1;
            // Nested exceptions keep the original return address.
            if (!status_q.exl) epc_d = i_pc;
        end else if (do_eret) begin
            status_d.exl = 1'b0;
        end else if (do_mtc0) begin
            case (i_cp0_addr)
                REG_STATUS: begin
                    status_d.ie  = i_wdata[ST_IE];
                    status_d.exl = i_wdata[ST_EXL];
                    status_d.im  = i_wdata[ST_IM_LSB +: 8];
                end
                REG_CAUSE: ip_sw_d = i_wdata[CA_IP_LSB +: 2];
                REG_EPC:   epc_d   = i_wdata;
                default:   ;
            endcase
        end
    end

    // Architectural state; hardware IP lines are resampled every clock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            status_q   <= STATUS_RST;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            status_q   <= status_d;
            ip_hw_q    <= i_hw_irq;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_count_we   (do_mtc0 && (i_cp0_addr == REG_COUNT)),
        .i_compare_we (do_mtc0 && (i_cp0_addr == REG_COMPARE)),
        .i_wdata      (i_wdata),
        .o_count      (count),
        .o_compare    (compare),
        .o_timer_flag (timer_flag)
    );

    // Combinational register read (pre-update values)
    always_comb begin
        case (i_cp0_addr)
            REG_COUNT:   o_rdata = count;
            REG_COMPARE: o_rdata = compare;
            REG_STATUS:  o_rdata = status_word(status_q);
            REG_CAUSE:   o_rdata = cause_word(cause_ip, exc_code_q);
            REG_EPC:     o_rdata = epc_q;
            default:     o_rdata = '0;
        endcase
    end

    assign o_exc_taken   = exc;
    assign o_redirect    = exc | do_eret;
    assign o_redirect_pc = exc ? EXC_VECTOR : (do_eret ? epc_q : 32'h0);

endmodule

// File: tb/tb_cp0_regs.sv
// Scoreboard bench for cp0_regs: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_cp0_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid, mtc0, mfc0, eret, unk, ovf;
    logic [31:0] pc, wdata;
    logic [4:0]  addr;
    logic [5:0]  hw_irq;
    logic [31:0] rdata, redirect_pc;
    logic        redirect, exc_taken;

    always #5 clk = ~clk;

    cp0_regs #(.EXC_VECTOR(32'h0000_0180), .COUNT_DIV(2)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_inst_valid   (inst_valid),
        .i_pc           (pc),
        .i_mtc0         (mtc0),
        .i_mfc0         (mfc0),
        .i_eret         (eret),
        .i_unknown_func (unk),
        .i_overflow     (ovf),
        .i_cp0_addr     (addr),
        .i_wdata        (wdata),
        .i_hw_irq       (hw_irq),
        .o_rdata        (rdata),
        .o_redirect     (redirect),
        .o_redirect_pc  (redirect_pc),
        .o_exc_taken    (exc_taken)
    );

    typedef struct {
        logic        exc;
        logic        redir;
        logic [31:0] rpc;
        logic        rchk;
        logic [31:0] rdata;
    } exp_t;

    exp_t  expq[$];
    string nameq[$];
    logic  chk = 1'b0;
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: one expectation per checked cycle
    always @(negedge clk) begin
        if (chk) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                exp_t  e;
                string n;
                e = expq.pop_front();
                n = nameq.pop_front();
                compare({n, ".exc"}, {31'b0, exc_taken}, {31'b0, e.exc});
                compare({n, ".redir"}, {31'b0, redirect}, {31'b0, e.redir});
                if (e.redir) compare({n, ".rpc"}, redirect_pc, e.rpc);
                if (e.rchk)  compare({n, ".rdata"}, rdata, e.rdata);
            end
        end
    end

    // Drive one cycle of inputs and queue what the DUT must show for it
    task automatic cyc(input string nm, input logic v, input logic [31:0] p,
                       input logic wr, input logic rd, input logic er,
                       input logic uf, input logic of, input logic [4:0] a,
                       input logic [31:0] wd, input logic x_exc, input logic x_redir,
                       input logic [31:0] x_rpc, input logic x_rchk, input logic [31:0] x_rdata);
        exp_t e;
        inst_valid = v; pc = p; mtc0 = wr; mfc0 = rd; eret = er;
        unk = uf; ovf = of; addr = a; wdata = wd;
        e.exc = x_exc; e.redir = x_redir; e.rpc = x_rpc; e.rchk = x_rchk; e.rdata = x_rdata;
        expq.push_back(e);
        nameq.push_back(nm);
        chk = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] x);
        cyc(nm, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, x);
    endtask

    task automatic wr(input string nm, input logic [4:0] a, input logic [31:0] d);
        cyc(nm, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a, d, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc("idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0,
                1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; hw_irq = 6'h0;
        inst_valid = 0; pc = 0; mtc0 = 0; mfc0 = 0; eret = 0; unk = 0; ovf = 0;
        addr = 0; wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state (cause read before Count==Compare match can register)
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_status", 5'd12, 32'h2);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_unmapped", 5'd5, 32'h0);
        idle(16);
        rd("count_div2", 5'd9, 32'd10);
        // mtc0 Count with same-cycle read: old value visible
        cyc("count_wr_old", 1'b1, 32'h108, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'hFFFF_FFFF,
            1'b0, 1'b0, 32'h0, 1'b1, 32'd10);
        rd("count_new", 5'd9, 32'hFFFF_FFFF);
        rd("count_presc", 5'd9, 32'hFFFF_FFFF);
        rd("count_wrap", 5'd9, 32'h0);

        // timer interrupt
        wr("wr_compare", 5'd11, 32'd20);
        rd("cause_flag_clr", 5'd13, 32'h0);
        wr("wr_status", 5'd12, 32'h0000_8001);
        idle(36);
        rd("count_eq_cmp", 5'd9, 32'd20);
        idle(1);
        cyc("timer_exc", 1'b1, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
            1'b1, 1'b1, 32'h180, 1'b0, 32'h0);
        rd("timer_epc", 5'd14, 32'h2000);
        rd("timer_cause", 5'd13, 32'h0000_8000);
        rd("timer_status", 5'd12, 32'h0000_8003);
        wr("ack_compare", 5'd11, 32'h0000_FFFF);
        rd("timer_ack", 5'd13, 32'h0);

        // reserved instruction with discarded mtc0 Status
        wr("reopen", 5'd12, 32'h0000_8001);
        cyc("ri_exc", 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd12, 32'h0000_FF00,
            1'b1, 1'b1, 32'h180, 1'b0, 32'h0);
        rd("ri_status", 5'd12, 32'h0000_8003);
        rd("ri_cause", 5'd13, 32'h0000_0028);
        rd("ri_epc", 5'd14, 32'h400);

        // nested overflow keeps EPC, then eret
        cyc("ov_exc", 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0,
            1'b1, 1'b1, 32'h180, 1'b0, 32'h0);
        rd("ov_cause", 5'd13, 32'h0000_0030);
        rd("ov_epc", 5'd14, 32'h400);
        cyc("eret", 1'b1, 32'h600, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0,
            1'b0, 1'b1, 32'h400, 1'b1, 32'h0000_8003);
        rd("eret_status", 5'd12, 32'h0000_8001);

        // masking by IM2, then unmask
        hw_irq = 6'h01;
        cyc("mask_inst", 1'b1, 32'h604, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
            1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rd("mask_cause", 5'd13, 32'h0000_0430);
        wr("set_im2", 5'd12, 32'h0000_0401);
        cyc("irq_exc", 1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
            1'b1, 1'b1, 32'h180, 1'b0, 32'h0);
        rd("irq_epc", 5'd14, 32'h700);
        rd("irq_cause", 5'd13, 32'h0000_0400);
        rd("irq_status", 5'd12, 32'h0000_0403);

        // asynchronous reset in the middle of an exception
        cyc("pre_rst_exc", 1'b1, 32'h800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0,
            1'b1, 1'b1, 32'h180, 1'b0, 32'h0);
        rst_n = 1'b0;
        cyc("rst_mid_status", 1'b1, 32'h900, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0,
            1'b0, 1'b0, 32'h0, 1'b1, 32'h2);
        cyc("rst_mid_epc", 1'b1, 32'h904, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd14, 32'h0,
            1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        hw_irq = 6'h0;
        rst_n  = 1'b1;
        rd("post_rst_status", 5'd12, 32'h2);

        chk = 1'b0;
        @(negedge clk);
        if (expq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
